// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types and constants for the idli SQI memory controller
//
// Contents:
//   sqi_state_t    controller FSM states
//   sqi_phase_t    position inside a nibble: low half, high half, write-data stall
//   sqi_io_mode_t  SIO pin direction (1 = controller tri-stated, memory drives)
//   SQI_CMD_*      serial SRAM opcodes
//   SQI_*_NIB      fixed phase lengths in nibbles
package idli_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } sqi_state_t;

  typedef enum logic [1:0] {
    PH_L,
    PH_H,
    PH_S
  } sqi_phase_t;

  typedef enum logic {
    IO_OUT = 1'b0,
    IO_IN  = 1'b1
  } sqi_io_mode_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam int         SQI_CMD_NIB   = 2;
  localparam int         SQI_ADDR_NIB  = 6;

endpackage

// File: rtl/idli_sqi_rbuf_m.sv
// rtl/idli_sqi_rbuf_m.sv - one-entry read nibble buffer between the SIO sampler and the core
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load, din   capture a nibble (takes priority over acp)
//   acp         consumer takes the held nibble this cycle
//   dout, vld   held nibble and its valid flag
//   full        buffer is occupied and will still be occupied next cycle
module idli_sqi_rbuf_m (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       acp,
  output logic [3:0] dout,
  output logic       vld,
  output logic       full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 4'h0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (acp) begin
      vld  <= 1'b0;
    end
  end

  // A same-cycle acp frees the slot, so the sampler may proceed.
  assign full = vld && !acp;

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// rtl/idli_sqi_ctrl_m.sv - SQI (quad-SPI) serial SRAM controller for the idli core
//
// Ports:
//   i_sqi_gck, i_sqi_rst_n                 clock, asynchronous active-low reset
//   i_sqi_req_* / o_sqi_req_acp            request channel (wr, byte address, nibble count - 1)
//   i_sqi_wdata* / o_sqi_wdata_acp         write nibble stream
//   o_sqi_rdata* / i_sqi_rdata_acp         read nibble stream
//   o_sqi_busy                             transaction in progress
//   o_sqi_mem_sck/cs/io_mode, *_mem_sio    memory pins (cs active low, io_mode 1 = input)
import idli_pkg::*;

module idli_sqi_ctrl_m #(
  parameter int ADDR_W      = 17,
  parameter int LEN_W       = 4,
  parameter int DUMMY_NIB   = 2,
  parameter int CS_HIGH_MIN = 1
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_req_vld,
  output logic              o_sqi_req_acp,
  input  logic              i_sqi_req_wr,
  input  logic [ADDR_W-1:0] i_sqi_req_addr,
  input  logic [LEN_W-1:0]  i_sqi_req_len,
  input  logic [3:0]        i_sqi_wdata,
  input  logic              i_sqi_wdata_vld,
  output logic              o_sqi_wdata_acp,
  output logic [3:0]        o_sqi_rdata,
  output logic              o_sqi_rdata_vld,
  input  logic              i_sqi_rdata_acp,
  output logic              o_sqi_busy,
  output logic              o_sqi_mem_sck,
  output logic              o_sqi_mem_cs,
  output logic              o_sqi_mem_io_mode,
  input  logic [3:0]        i_sqi_mem_sio,
  output logic [3:0]        o_sqi_mem_sio
);

  localparam int GAP_W = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;

  sqi_state_t        state, state_nxt;
  sqi_phase_t        ph, ph_nxt;
  logic [2:0]        nib, nib_nxt;
  logic [LEN_W:0]    dcnt, dcnt_nxt;
  logic [GAP_W-1:0]  gcnt, gcnt_nxt;
  logic              wr_q, wr_nxt;
  logic [23:0]       addr_q, addr_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [3:0]        sio_q, sio_nxt;
  logic              rbuf_load;
  logic              rbuf_full;
  logic [7:0]        cmd_req, cmd_cur;
  logic              active;

  assign cmd_req = i_sqi_req_wr ? SQI_CMD_WRITE : SQI_CMD_READ;
  assign cmd_cur = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state  <= IDLE;
      ph     <= PH_L;
      nib    <= 3'd0;
      dcnt   <= '0;
      gcnt   <= '0;
      wr_q   <= 1'b0;
      addr_q <= 24'h0;
      len_q  <= '0;
      sio_q  <= 4'h0;
    end else begin
      state  <= state_nxt;
      ph     <= ph_nxt;
      nib    <= nib_nxt;
      dcnt   <= dcnt_nxt;
      gcnt   <= gcnt_nxt;
      wr_q   <= wr_nxt;
      addr_q <= addr_nxt;
      len_q  <= len_nxt;
      sio_q  <= sio_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ph_nxt          = ph;
    nib_nxt         = nib;
    dcnt_nxt        = dcnt;
    gcnt_nxt        = gcnt;
    wr_nxt          = wr_q;
    addr_nxt        = addr_q;
    len_nxt         = len_q;
    sio_nxt         = sio_q;
    o_sqi_wdata_acp = 1'b0;
    rbuf_load       = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_sqi_req_vld) begin
          state_nxt = CMD;
          ph_nxt    = PH_L;
          nib_nxt   = 3'd0;
          wr_nxt    = i_sqi_req_wr;
          addr_nxt  = 24'(i_sqi_req_addr);
          len_nxt   = i_sqi_req_len;
          sio_nxt   = cmd_req[7:4];
        end
      end

      CMD: begin
        if (ph == PH_L) begin
          ph_nxt = PH_H;
        end else begin
          ph_nxt = PH_L;
          if (nib == 3'(SQI_CMD_NIB - 1)) begin
            state_nxt = ADDR;
            nib_nxt   = 3'd0;
            sio_nxt   = addr_q[23:20];
            addr_nxt  = {addr_q[19:0], 4'h0};
          end else begin
            nib_nxt = nib + 3'd1;
            sio_nxt = cmd_cur[3:0];
          end
        end
      end

      ADDR: begin
        if (ph == PH_L) begin
          ph_nxt = PH_H;
        end else if (nib == 3'(SQI_ADDR_NIB - 1)) begin
          nib_nxt  = 3'd0;
          dcnt_nxt = '0;
          if (wr_q) begin
            // The last address H doubles as the handshake slot for data nibble 0.
            state_nxt       = DATA;
            o_sqi_wdata_acp = i_sqi_wdata_vld;
            ph_nxt          = i_sqi_wdata_vld ? PH_L : PH_S;
            if (i_sqi_wdata_vld) sio_nxt = i_sqi_wdata;
          end else begin
            state_nxt = (DUMMY_NIB == 0) ? DATA : DUMMY;
            ph_nxt    = PH_L;
            sio_nxt   = 4'h0;
          end
        end else begin
          ph_nxt   = PH_L;
          nib_nxt  = nib + 3'd1;
          sio_nxt  = addr_q[23:20];
          addr_nxt = {addr_q[19:0], 4'h0};
        end
      end

      DUMMY: begin
        if (ph == PH_L) begin
          ph_nxt = PH_H;
        end else begin
          ph_nxt = PH_L;
          if (nib == 3'(DUMMY_NIB - 1)) begin
            state_nxt = DATA;
            nib_nxt   = 3'd0;
            dcnt_nxt  = '0;
          end else begin
            nib_nxt = nib + 3'd1;
          end
        end
      end

      DATA: begin
        unique case (ph)
          PH_L: begin
            // Hold L while the core has not drained the previous read nibble.
            if (wr_q || !rbuf_full) ph_nxt = PH_H;
          end
          PH_H: begin
            if (!wr_q) rbuf_load = 1'b1;
            if (dcnt == {1'b0, len_q}) begin
              state_nxt = GAP;
              ph_nxt    = PH_L;
              gcnt_nxt  = '0;
            end else begin
              dcnt_nxt = dcnt + 1'b1;
              if (wr_q) begin
                o_sqi_wdata_acp = i_sqi_wdata_vld;
                ph_nxt          = i_sqi_wdata_vld ? PH_L : PH_S;
                if (i_sqi_wdata_vld) sio_nxt = i_sqi_wdata;
              end else begin
                ph_nxt = PH_L;
              end
            end
          end
          default: begin
            // Write stall: pins frozen with sck low until the core supplies a nibble.
            o_sqi_wdata_acp = i_sqi_wdata_vld;
            if (i_sqi_wdata_vld) begin
              ph_nxt  = PH_L;
              sio_nxt = i_sqi_wdata;
            end
          end
        endcase
      end

      GAP: begin
        if (gcnt == GAP_W'(CS_HIGH_MIN - 1)) begin
          state_nxt = IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        ph_nxt    = PH_L;
      end
    endcase
  end

  idli_sqi_rbuf_m u_rbuf (
    .clk   (i_sqi_gck),
    .rst_n (i_sqi_rst_n),
    .load  (rbuf_load),
    .din   (i_sqi_mem_sio),
    .acp   (i_sqi_rdata_acp),
    .dout  (o_sqi_rdata),
    .vld   (o_sqi_rdata_vld),
    .full  (rbuf_full)
  );

  assign active            = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
  assign o_sqi_req_acp     = (state == IDLE);
  assign o_sqi_busy        = (state != IDLE);
  assign o_sqi_mem_cs      = !active;
  assign o_sqi_mem_sck     = active && (ph == PH_H);
  assign o_sqi_mem_sio     = sio_q;
  // Controller drives SIO only for CMD, ADDR and write data.
  assign o_sqi_mem_io_mode = ((state == CMD) || (state == ADDR) || ((state == DATA) && wr_q))
                             ? IO_OUT : IO_IN;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb/tb_idli_sqi_ctrl_m.sv - self-checking bench for idli_sqi_ctrl_m
module tb_idli_sqi_ctrl_m;

  localparam int ADDR_W      = 17;
  localparam int LEN_W       = 4;
  localparam int DUMMY_NIB   = 2;
  localparam int CS_HIGH_MIN = 1;
  localparam int WR_H0       = 8;
  localparam int RD_H0       = 8 + DUMMY_NIB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_vld = 1'b0;
  logic              req_acp;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [3:0]        wdata = 4'h0;
  logic              wdata_vld = 1'b0;
  logic              wdata_acp;
  logic [3:0]        rdata;
  logic              rdata_vld;
  logic              rdata_acp = 1'b0;
  logic              busy;
  logic              sck;
  logic              cs;
  logic              io_mode;
  logic [3:0]        sio_in;
  logic [3:0]        sio_out;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;

  int h_cnt = 0;
  int data_h0 = RD_H0;
  int data_l_cnt = 0;
  logic [3:0] pin_q[$];
  logic [3:0] mem_nib [16];

  idli_sqi_ctrl_m #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DUMMY_NIB(DUMMY_NIB), .CS_HIGH_MIN(CS_HIGH_MIN)
  ) dut (
    .i_sqi_gck         (clk),
    .i_sqi_rst_n       (rst_n),
    .i_sqi_req_vld     (req_vld),
    .o_sqi_req_acp     (req_acp),
    .i_sqi_req_wr      (req_wr),
    .i_sqi_req_addr    (req_addr),
    .i_sqi_req_len     (req_len),
    .i_sqi_wdata       (wdata),
    .i_sqi_wdata_vld   (wdata_vld),
    .o_sqi_wdata_acp   (wdata_acp),
    .o_sqi_rdata       (rdata),
    .o_sqi_rdata_vld   (rdata_vld),
    .i_sqi_rdata_acp   (rdata_acp),
    .o_sqi_busy        (busy),
    .o_sqi_mem_sck     (sck),
    .o_sqi_mem_cs      (cs),
    .o_sqi_mem_io_mode (io_mode),
    .i_sqi_mem_sio     (sio_in),
    .o_sqi_mem_sio     (sio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: records o_sio at each H, counts data-phase sck-low cycles.
  always @(negedge clk) begin
    if (cs) h_cnt = 0;
    else if (sck) begin pin_q.push_back(sio_out); h_cnt = h_cnt + 1; end
    else if (h_cnt >= data_h0) data_l_cnt = data_l_cnt + 1;
  end

  // Memory model: during read data H number i it presents mem_nib[i].
  assign sio_in = (h_cnt >= RD_H0 + 1) ? mem_nib[4'(h_cnt - RD_H0 - 1)] : 4'h0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic start_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, output int t);
    nchk++; if (req_acp !== 1'b1) begin nerr++; $display("FAIL req_acp_idle got=%b exp=1", req_acp); end
    req_wr = wr; req_addr = a; req_len = l; req_vld = 1'b1; t = cyc;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wdata_vld = 1'b1; rdata_acp = 1'b0;
    repeat (2) @(negedge clk);
    nchk++; if (sck !== 1'b0)     begin nerr++; $display("FAIL rst_sck got=%b exp=0", sck); end
    nchk++; if (cs !== 1'b1)      begin nerr++; $display("FAIL rst_cs got=%b exp=1", cs); end
    nchk++; if (io_mode !== 1'b1) begin nerr++; $display("FAIL rst_io_mode got=%b exp=1", io_mode); end
    nchk++; if (sio_out !== 4'h0) begin nerr++; $display("FAIL rst_sio got=%h exp=0", sio_out); end
    nchk++; if (req_acp !== 1'b1) begin nerr++; $display("FAIL rst_req_acp got=%b exp=1", req_acp); end
    nchk++; if (wdata_acp !== 1'b0) begin nerr++; $display("FAIL rst_wdata_acp got=%b exp=0", wdata_acp); end
    nchk++; if (rdata !== 4'h0)   begin nerr++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    nchk++; if (rdata_vld !== 1'b0) begin nerr++; $display("FAIL rst_rdata_vld got=%b exp=0", rdata_vld); end
    nchk++; if (busy !== 1'b0)    begin nerr++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1; wdata_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_single();
    int t, p0;
    logic [3:0] exp_p [8];
    exp_p = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
    mem_nib[0] = 4'hA; data_h0 = RD_H0; p0 = pin_q.size();
    start_req(1'b0, 17'h00123, 4'd0, t);
    nchk++; if ({cs, sck, io_mode} !== 3'b000) begin nerr++; $display("FAIL rd_cmd_start got=%b exp=000", {cs, sck, io_mode}); end
    while (cyc < t + 16) @(negedge clk);
    nchk++; if ({sck, io_mode} !== 2'b10) begin nerr++; $display("FAIL rd_last_addr_h got=%b exp=10", {sck, io_mode}); end
    @(negedge clk);
    nchk++; if ({cs, sck, io_mode} !== 3'b001) begin nerr++; $display("FAIL rd_dummy_turn got=%b exp=001", {cs, sck, io_mode}); end
    while (cyc < t + 22) @(negedge clk);
    nchk++; if ({sck, rdata_vld} !== 2'b10) begin nerr++; $display("FAIL rd_data_h got=%b exp=10", {sck, rdata_vld}); end
    @(negedge clk);
    nchk++; if ({rdata_vld, cs, busy} !== 3'b111) begin nerr++; $display("FAIL rd_t23 got=%b exp=111", {rdata_vld, cs, busy}); end
    nchk++; if (rdata !== 4'hA) begin nerr++; $display("FAIL rd_data got=%h exp=a", rdata); end
    rdata_acp = 1'b1;
    @(negedge clk);
    rdata_acp = 1'b0;
    nchk++; if ({req_acp, rdata_vld} !== 2'b10) begin nerr++; $display("FAIL rd_t24 got=%b exp=10", {req_acp, rdata_vld}); end
    nchk++; if (pin_q.size() - p0 !== 11) begin nerr++; $display("FAIL rd_h_count got=%0d exp=11", pin_q.size() - p0); end
    for (int i = 0; i < 8; i++) begin
      nchk++; if (pin_q[p0 + i] !== exp_p[i]) begin nerr++; $display("FAIL rd_pin%0d got=%h exp=%h", i, pin_q[p0 + i], exp_p[i]); end
    end
  endtask

  task automatic test_write_burst();
    int t, p0, l0, idx;
    logic [3:0] exp_p [12];
    logic [3:0] wq [4];
    exp_p = '{4'h0, 4'h2, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
    wq = '{4'h1, 4'h2, 4'h3, 4'h4};
    data_h0 = WR_H0; p0 = pin_q.size(); l0 = data_l_cnt; idx = 0;
    start_req(1'b1, 17'h1FFFF, 4'd3, t);
    for (int k = 0; k < 30; k++) begin
      if (cyc == t + 17) begin nchk++; if ({cs, sck, io_mode, sio_out} !== 7'b0000001) begin nerr++; $display("FAIL wr_first_l got=%b exp=0000001", {cs, sck, io_mode, sio_out}); end end
      if (cyc == t + 24) begin nchk++; if (cs !== 1'b0) begin nerr++; $display("FAIL wr_cs_t24 got=%b exp=0", cs); end end
      if (cyc == t + 25) begin nchk++; if ({cs, io_mode} !== 2'b11) begin nerr++; $display("FAIL wr_cs_t25 got=%b exp=11", {cs, io_mode}); end end
      wdata = (idx < 4) ? wq[idx] : 4'h0; wdata_vld = (idx < 4);
      #1;
      if (wdata_acp) idx++;
      @(negedge clk);
    end
    wdata_vld = 1'b0;
    nchk++; if (idx !== 4) begin nerr++; $display("FAIL wr_taken got=%0d exp=4", idx); end
    nchk++; if (data_l_cnt - l0 !== 4) begin nerr++; $display("FAIL wr_no_stall got=%0d exp=4", data_l_cnt - l0); end
    nchk++; if (pin_q.size() - p0 !== 12) begin nerr++; $display("FAIL wr_h_count got=%0d exp=12", pin_q.size() - p0); end
    for (int i = 0; i < 12; i++) begin
      nchk++; if (pin_q[p0 + i] !== exp_p[i]) begin nerr++; $display("FAIL wr_pin%0d got=%h exp=%h", i, pin_q[p0 + i], exp_p[i]); end
    end
  endtask

  task automatic test_write_stall();
    int t, p0, l0, idx;
    logic [3:0] wq [2];
    wq = '{4'h9, 4'h6};
    data_h0 = WR_H0; p0 = pin_q.size(); l0 = data_l_cnt; idx = 0;
    start_req(1'b1, 17'h00ABC, 4'd1, t);
    for (int k = 0; k < 30; k++) begin
      if (cyc >= t + 19 && cyc <= t + 23) begin
        nchk++; if ({cs, sck, sio_out} !== 6'b001001) begin nerr++; $display("FAIL st_stall_c%0d got=%b exp=001001", cyc - t, {cs, sck, sio_out}); end
      end
      if (cyc == t + 24) begin nchk++; if ({cs, sck, sio_out} !== 6'b000110) begin nerr++; $display("FAIL st_l1 got=%b exp=000110", {cs, sck, sio_out}); end end
      if (cyc == t + 25) begin nchk++; if ({cs, sck} !== 2'b01) begin nerr++; $display("FAIL st_h1 got=%b exp=01", {cs, sck}); end end
      if (cyc == t + 26) begin nchk++; if (cs !== 1'b1) begin nerr++; $display("FAIL st_cs_end got=%b exp=1", cs); end end
      wdata = (idx < 2) ? wq[idx] : 4'h0;
      wdata_vld = (idx < 2) && !(cyc >= t + 18 && cyc <= t + 22);
      #1;
      if (wdata_acp) idx++;
      @(negedge clk);
    end
    wdata_vld = 1'b0;
    nchk++; if (idx !== 2) begin nerr++; $display("FAIL st_taken got=%0d exp=2", idx); end
    nchk++; if (data_l_cnt - l0 !== 7) begin nerr++; $display("FAIL st_low_cycles got=%0d exp=7", data_l_cnt - l0); end
    nchk++; if (pin_q.size() - p0 !== 10) begin nerr++; $display("FAIL st_h_count got=%0d exp=10", pin_q.size() - p0); end
    nchk++; if ({pin_q[p0 + 8], pin_q[p0 + 9]} !== 8'h96) begin nerr++; $display("FAIL st_data got=%h exp=96", {pin_q[p0 + 8], pin_q[p0 + 9]}); end
  endtask

  task automatic test_read_backpressure();
    int t, l0, got_n, hold_left, bp_err;
    logic [3:0] got [16];
    for (int i = 0; i < 16; i++) mem_nib[i] = 4'(i * 7 + 3);
    data_h0 = RD_H0; l0 = data_l_cnt; got_n = 0; hold_left = 0; bp_err = 0;
    start_req(1'b0, 17'h0ABCD, 4'd15, t);
    for (int k = 0; k < 200 && !(got_n == 16 && cs); k++) begin
      if (sck && rdata_vld) bp_err++;
      if (hold_left > 0) begin
        rdata_acp = 1'b0; hold_left--;
      end else if (rdata_vld && got_n < 16) begin
        got[got_n] = rdata; got_n++; rdata_acp = 1'b1;
        if (got_n == 3) hold_left = 10;
      end else begin
        rdata_acp = 1'b1;
      end
      @(negedge clk);
    end
    rdata_acp = 1'b0;
    nchk++; if (got_n !== 16) begin nerr++; $display("FAIL bp_count got=%0d exp=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      nchk++; if (got[i] !== 4'(i * 7 + 3)) begin nerr++; $display("FAIL bp_nib%0d got=%h exp=%h", i, got[i], 4'(i * 7 + 3)); end
    end
    nchk++; if (bp_err !== 0) begin nerr++; $display("FAIL bp_h_while_full got=%0d exp=0", bp_err); end
    nchk++; if (data_l_cnt - l0 !== 25) begin nerr++; $display("FAIL bp_low_cycles got=%0d exp=25", data_l_cnt - l0); end
  endtask

  task automatic test_reset_mid();
    int t, p0, idx;
    logic [3:0] exp_p [9];
    exp_p = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h2, 4'hE};
    data_h0 = RD_H0;
    start_req(1'b0, 17'h05555, 4'd0, t);
    while (cyc < t + 8) @(negedge clk);
    nchk++; if ({cs, busy} !== 2'b01) begin nerr++; $display("FAIL mr_pre got=%b exp=01", {cs, busy}); end
    #1 rst_n = 1'b0;
    #1;
    nchk++; if ({cs, sck, io_mode, busy, req_acp} !== 5'b10101) begin nerr++; $display("FAIL mr_async got=%b exp=10101", {cs, sck, io_mode, busy, req_acp}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data_h0 = WR_H0; p0 = pin_q.size(); idx = 0;
    start_req(1'b1, 17'h00042, 4'd0, t);
    for (int k = 0; k < 25; k++) begin
      if (cyc == t + 18) begin nchk++; if ({cs, sck} !== 2'b01) begin nerr++; $display("FAIL mr_data_h got=%b exp=01", {cs, sck}); end end
      if (cyc == t + 19) begin nchk++; if (cs !== 1'b1) begin nerr++; $display("FAIL mr_cs_end got=%b exp=1", cs); end end
      wdata = 4'hE; wdata_vld = (idx < 1);
      #1;
      if (wdata_acp) idx++;
      @(negedge clk);
    end
    wdata_vld = 1'b0;
    nchk++; if (pin_q.size() - p0 !== 9) begin nerr++; $display("FAIL mr_h_count got=%0d exp=9", pin_q.size() - p0); end
    for (int i = 0; i < 9; i++) begin
      nchk++; if (pin_q[p0 + i] !== exp_p[i]) begin nerr++; $display("FAIL mr_pin%0d got=%h exp=%h", i, pin_q[p0 + i], exp_p[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int t, c;
    data_h0 = RD_H0; rdata_acp = 1'b1;
    req_wr = 1'b0; req_addr = 17'h00010; req_len = 4'd0; req_vld = 1'b1; t = cyc;
    for (int k = 0; k < 56; k++) begin
      c = cyc - t;
      nchk++; if (req_acp !== !busy) begin nerr++; $display("FAIL b2b_acp_idle c%0d got=%b exp=%b", c, req_acp, !busy); end
      if (c == 22) begin nchk++; if (cs !== 1'b0) begin nerr++; $display("FAIL b2b_c22 got=%b exp=0", cs); end end
      if (c == 23) begin nchk++; if ({cs, req_acp} !== 2'b10) begin nerr++; $display("FAIL b2b_c23 got=%b exp=10", {cs, req_acp}); end end
      if (c == 24) begin nchk++; if ({cs, req_acp} !== 2'b11) begin nerr++; $display("FAIL b2b_c24 got=%b exp=11", {cs, req_acp}); end end
      if (c == 25) begin nchk++; if ({cs, req_acp} !== 2'b00) begin nerr++; $display("FAIL b2b_c25 got=%b exp=00", {cs, req_acp}); end end
      if (c == 46) begin nchk++; if (cs !== 1'b0) begin nerr++; $display("FAIL b2b_c46 got=%b exp=0", cs); end end
      if (c == 47) begin nchk++; if (cs !== 1'b1) begin nerr++; $display("FAIL b2b_c47 got=%b exp=1", cs); end end
      if (c == 40) req_vld = 1'b0;
      @(negedge clk);
    end
    rdata_acp = 1'b0;
    nchk++; if ({busy, rdata_vld} !== 2'b00) begin nerr++; $display("FAIL b2b_end got=%b exp=00", {busy, rdata_vld}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read_single();
    test_write_burst();
    test_write_stall();
    test_read_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
